sad_search_sequencer: RTL and testbench
=======================================

SAD_SEARCH_SEQUENCER -- requirements
Module: sad_search_sequencer

Interface
REQ-001 SHALL provide parameter ROWS, default 4, meaning adder-tree beats per candidate window (legal range 1..8).
REQ-002 SHALL provide parameter ACC_W, default 16, meaning accumulator and Best_SAD width (>= 13 + clog2(ROWS)).
REQ-003 SHALL provide parameter CNT_W, default 12, meaning width of the candidate-pair count.
REQ-004 Clk  input  1  system clock; all state updates on rising edge.
REQ-005 Rst_n  input  1  synchronous, active-low reset.
REQ-006 Start  input  1  begin a search; sampled only in IDLE.
REQ-007 NumPairs  input  CNT_W  number of candidate pairs (A,B) to evaluate; sampled with Start.
REQ-008 In_Valid  input  1  SAD_value_small_A/B carry a valid beat.
REQ-009 SAD_value_small_A  input  13  adder-tree partial sum, candidate A.
REQ-010 SAD_value_small_B  input  13  adder-tree partial sum, candidate B.
REQ-011 In_Ready  output  1  sequencer accepts a beat this cycle.
REQ-012 Busy  output  1  high in every state except IDLE.
REQ-013 Done  output  1  one-cycle completion pulse.
REQ-014 Best_SAD  output  ACC_W  minimum window SAD found.
REQ-015 Best_Index  output  CNT_W+1  index of best candidate; A of pair k = 2k, B of pair k = 2k+1.

Function
REQ-016 SHALL implement FSM states IDLE, ACCUM, COMPARE, DONE.
REQ-017 IDLE: Start=1 -> load pair counter 0, clear both accumulators, Best_SAD <= all ones, Best_Index <= 0; go ACCUM if NumPairs != 0, else DONE.
REQ-018 Start while Busy SHALL be ignored; NumPairs changes after Start SHALL have no effect.
REQ-019 In_Ready SHALL be 1 exactly when state is ACCUM (combinational from state only, not from In_Valid).
REQ-020 A beat is accepted when In_Valid && In_Ready; accA += zero-extended A, accB += zero-extended B, beat counter += 1.
REQ-021 In_Valid=0 in ACCUM SHALL stall with accumulators and counters unchanged; no timeout.
REQ-022 On the ROWS-th accepted beat, next state SHALL be COMPARE (that beat included in sums).
REQ-023 COMPARE (one cycle): if accA < Best_SAD, candidate A wins; then B replaces the winner only if accB < min(accA-or-Best_SAD); strict less-than so ties keep the lower index.
REQ-024 COMPARE SHALL clear accumulators and beat counter, increment pair counter; go DONE if pair counter+1 == NumPairs, else ACCUM.
REQ-025 DONE: Done=1 for exactly that cycle, next state IDLE.
REQ-026 Best_SAD/Best_Index SHALL hold their values in IDLE until the next accepted Start.
REQ-027 Latency: Start accepted at edge t0 with continuous In_Valid -> Done high in cycle t0 + NumPairs*(ROWS+1) + 1.
REQ-028 Accumulators SHALL not overflow within legal ROWS; no saturation logic required.

Reset
REQ-029 Rst_n=0 at a rising edge SHALL force IDLE from any state, including mid-ACCUM or COMPARE.
REQ-030 Reset values: In_Ready=0, Busy=0, Done=0, Best_SAD=0, Best_Index=0, accumulators and counters 0.
REQ-031 A Start asserted in the same cycle as Rst_n=0 SHALL be ignored.

Verification
REQ-032 ROWS=4, NumPairs=1, A beats 10,20,30,40, B beats 5,5,5,5, In_Valid held -> Done at t0+6, Best_SAD=20, Best_Index=1.
REQ-033 NumPairs=2, pair0 A=100 B=100 total, pair1 A=100 B=60 -> tie keeps index 0 at pair0, final Best_SAD=60, Best_Index=3, Done at t0+11.
REQ-034 NumPairs=0 with Start -> Done one cycle later at t0+1, Best_SAD=16'hFFFF, Best_Index=0, In_Ready never 1.
REQ-035 In_Valid toggled 1,0,0,1,1,0,1 in ACCUM -> only 4 beats accepted, sums identical to gap-free run, Done delayed by 3 cycles.
REQ-036 Rst_n=0 after 2 accepted beats -> next cycle IDLE, Busy=0, Best_SAD=0; subsequent Start runs a fresh search with no residual sum.
REQ-037 Start pulsed while Busy, and all-max inputs 8191 per beat with ROWS=8 -> second Start ignored, Best_SAD=65528, no wrap.

Source files
------------

// File: rtl/sad_search_sequencer_if.sv
// Handshake and result bus between a block-matching adder tree and the
// SAD search sequencer. The sequencer side uses the slave modport; whoever
// feeds beats and launches searches uses the master modport.
interface sad_search_sequencer_if #(
   parameter int ACC_W = 16,
   parameter int CNT_W = 12
);
   logic             Start;
   logic [CNT_W-1:0] NumPairs;
   logic             In_Valid;
   logic [12:0]      SAD_value_small_A;
   logic [12:0]      SAD_value_small_B;
   logic             In_Ready;
   logic             Busy;
   logic             Done;
   logic [ACC_W-1:0] Best_SAD;
   logic [CNT_W:0]   Best_Index;

   modport master (
      output Start, NumPairs, In_Valid, SAD_value_small_A, SAD_value_small_B,
      input  In_Ready, Busy, Done, Best_SAD, Best_Index
   );

   modport slave (
      input  Start, NumPairs, In_Valid, SAD_value_small_A, SAD_value_small_B,
      output In_Ready, Busy, Done, Best_SAD, Best_Index
   );
endinterface

// File: rtl/sad_search_sequencer.sv
// Sequences a minimum-SAD search over pairs of candidate windows. Each
// window arrives as ROWS partial sums from an adder tree; A and B of a pair
// are accumulated side by side, then compared against the running best.
// Candidate A of pair k has index 2k, candidate B has index 2k+1.
module sad_search_sequencer #(
   parameter int ROWS  = 4,
   parameter int ACC_W = 16,
   parameter int CNT_W = 12
) (
   input logic Clk,
   input logic Rst_n,
   sad_search_sequencer_if.slave bus
);

   localparam int BEAT_W = $clog2(ROWS + 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCUM   = 2'd1,
      COMPARE = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    pair_cnt_q, pair_cnt_d;
   logic [CNT_W-1:0]    num_pairs_q, num_pairs_d;
   logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
   logic [ACC_W-1:0]    acc_a_q, acc_a_d;
   logic [ACC_W-1:0]    acc_b_q, acc_b_d;
   logic [ACC_W-1:0]    best_sad_q, best_sad_d;
   logic [CNT_W:0]      best_idx_q, best_idx_d;

   logic [CNT_W-1:0]    pair_next;
   logic [ACC_W-1:0]    min_after_a;
   logic [CNT_W:0]      idx_after_a;

   // State register; synchronous active-low reset returns everything to IDLE
   // with cleared results, which also drops any Start seen in the same cycle.
   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state_q     <= IDLE;
         pair_cnt_q  <= '0;
         num_pairs_q <= '0;
         beat_cnt_q  <= '0;
         acc_a_q     <= '0;
         acc_b_q     <= '0;
         best_sad_q  <= '0;
         best_idx_q  <= '0;
      end else begin
         state_q     <= state_d;
         pair_cnt_q  <= pair_cnt_d;
         num_pairs_q <= num_pairs_d;
         beat_cnt_q  <= beat_cnt_d;
         acc_a_q     <= acc_a_d;
         acc_b_q     <= acc_b_d;
         best_sad_q  <= best_sad_d;
         best_idx_q  <= best_idx_d;
      end
   end

   // Next-state logic: launch, accumulate beats, compare A then B with strict
   // less-than so ties keep the lower index, then advance to the next pair.
   always_comb begin
      state_d     = state_q;
      pair_cnt_d  = pair_cnt_q;
      num_pairs_d = num_pairs_q;
      beat_cnt_d  = beat_cnt_q;
      acc_a_d     = acc_a_q;
      acc_b_d     = acc_b_q;
      best_sad_d  = best_sad_q;
      best_idx_d  = best_idx_q;
      pair_next   = pair_cnt_q + CNT_W'(1);
      min_after_a = best_sad_q;
      idx_after_a = best_idx_q;

      case (state_q)
         IDLE: begin
            if (bus.Start) begin
               pair_cnt_d  = '0;
               num_pairs_d = bus.NumPairs;
               beat_cnt_d  = '0;
               acc_a_d     = '0;
               acc_b_d     = '0;
               best_sad_d  = '1;
               best_idx_d  = '0;
               state_d     = (bus.NumPairs != '0) ? ACCUM : DONE;
            end
         end
         ACCUM: begin
            if (bus.In_Valid) begin
               acc_a_d    = acc_a_q + ACC_W'(bus.SAD_value_small_A);
               acc_b_d    = acc_b_q + ACC_W'(bus.SAD_value_small_B);
               beat_cnt_d = beat_cnt_q + BEAT_W'(1);
               if (beat_cnt_q == BEAT_W'(ROWS - 1)) begin
                  state_d = COMPARE;
               end
            end
         end
         COMPARE: begin
            if (acc_a_q < best_sad_q) begin
               min_after_a = acc_a_q;
               idx_after_a = {pair_cnt_q, 1'b0};
            end
            best_sad_d = min_after_a;
            best_idx_d = idx_after_a;
            if (acc_b_q < min_after_a) begin
               best_sad_d = acc_b_q;
               best_idx_d = {pair_cnt_q, 1'b1};
            end
            acc_a_d    = '0;
            acc_b_d    = '0;
            beat_cnt_d = '0;
            pair_cnt_d = pair_next;
            state_d    = (pair_next == num_pairs_q) ? DONE : ACCUM;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.In_Ready   = (state_q == ACCUM);
   assign bus.Busy       = (state_q != IDLE);
   assign bus.Done       = (state_q == DONE);
   assign bus.Best_SAD   = best_sad_q;
   assign bus.Best_Index = best_idx_q;

endmodule

// File: tb/tb_sad_search_sequencer.sv
// Directed bench for sad_search_sequencer. Two instances are used: one with
// ROWS=4 for the main scenarios and one with ROWS=8 for the full-scale
// accumulation case. Expected values are worked out by hand per scenario.
module tb_sad_search_sequencer;

   logic        clk;
   logic        rst_n;
   logic        start4;
   logic        start8;
   logic [11:0] num_pairs;
   logic        in_valid;
   logic [12:0] sad_a;
   logic [12:0] sad_b;

   int vectors;
   int miscompares;

   int qa[$];
   int qb[$];
   int vpat[$];

   sad_search_sequencer_if #(.ACC_W(16), .CNT_W(12)) if4 ();
   sad_search_sequencer_if #(.ACC_W(16), .CNT_W(12)) if8 ();

   assign if4.Start             = start4;
   assign if4.NumPairs          = num_pairs;
   assign if4.In_Valid          = in_valid;
   assign if4.SAD_value_small_A = sad_a;
   assign if4.SAD_value_small_B = sad_b;

   assign if8.Start             = start8;
   assign if8.NumPairs          = num_pairs;
   assign if8.In_Valid          = in_valid;
   assign if8.SAD_value_small_A = sad_a;
   assign if8.SAD_value_small_B = sad_b;

   sad_search_sequencer #(.ROWS(4), .ACC_W(16), .CNT_W(12)) dut4 (
      .Clk   (clk),
      .Rst_n (rst_n),
      .bus   (if4.slave)
   );

   sad_search_sequencer #(.ROWS(8), .ACC_W(16), .CNT_W(12)) dut8 (
      .Clk   (clk),
      .Rst_n (rst_n),
      .bus   (if8.slave)
   );

   // Free-running 10-unit clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Launches a search on the selected instance and feeds beats from qa/qb.
   // vpat gives In_Valid for successive ready cycles (1 once exhausted).
   // cycles counts edges after the Start edge until Done is seen.
   task automatic run_search(input bit sel, input int n_pairs, input int restart_at,
                             output int cycles, output bit timed_out, output bit saw_ready);
      int vidx;
      bit rdy;
      bit dn;
      bit v;
      num_pairs = 12'(n_pairs);
      if (sel) start8 = 1'b1;
      else     start4 = 1'b1;
      @(posedge clk);
      #1;
      start4    = 1'b0;
      start8    = 1'b0;
      num_pairs = 12'd7;
      cycles    = 0;
      timed_out = 1'b0;
      saw_ready = 1'b0;
      vidx      = 0;
      forever begin
         dn = sel ? if8.Done : if4.Done;
         if (dn) break;
         if (cycles >= 300) begin
            timed_out = 1'b1;
            break;
         end
         rdy = sel ? if8.In_Ready : if4.In_Ready;
         if (rdy) saw_ready = 1'b1;
         v = 1'b1;
         if (rdy && vidx < vpat.size()) v = (vpat[vidx] != 0);
         if (rdy) vidx++;
         in_valid = v;
         sad_a    = (qa.size() > 0) ? 13'(qa[0]) : 13'd0;
         sad_b    = (qb.size() > 0) ? 13'(qb[0]) : 13'd0;
         if (cycles == restart_at) begin
            num_pairs = 12'd3;
            if (sel) start8 = 1'b1;
            else     start4 = 1'b1;
         end else begin
            start4 = 1'b0;
            start8 = 1'b0;
         end
         @(posedge clk);
         if (v && rdy && qa.size() > 0) begin
            void'(qa.pop_front());
            void'(qb.pop_front());
         end
         #1;
         cycles++;
      end
      in_valid = 1'b0;
      start4   = 1'b0;
      start8   = 1'b0;
   endtask

   task automatic test_reset();
      rst_n    = 1'b0;
      start4   = 1'b1;
      start8   = 1'b1;
      in_valid = 1'b1;
      num_pairs = 12'd1;
      sad_a    = 13'd0;
      sad_b    = 13'd0;
      @(posedge clk);
      @(posedge clk);
      #1;
      vectors++;
      if (if4.Busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %0b expected 0", if4.Busy); end
      vectors++;
      if (if4.Done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done: got %0b expected 0", if4.Done); end
      vectors++;
      if (if4.In_Ready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ready: got %0b expected 0", if4.In_Ready); end
      vectors++;
      if (if4.Best_SAD !== 16'd0) begin miscompares++; $display("[TB] FAIL reset_best_sad: got %0d expected 0", if4.Best_SAD); end
      vectors++;
      if (if4.Best_Index !== 13'd0) begin miscompares++; $display("[TB] FAIL reset_best_idx: got %0d expected 0", if4.Best_Index); end
      vectors++;
      if (if8.Busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy8: got %0b expected 0", if8.Busy); end
      start4   = 1'b0;
      start8   = 1'b0;
      in_valid = 1'b0;
      rst_n    = 1'b1;
      @(posedge clk);
      #1;
      vectors++;
      if (if4.Busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_start_ignored: busy got %0b expected 0", if4.Busy); end
   endtask

   task automatic test_single_pair();
      int cyc; bit to; bit sr;
      qa = '{10, 20, 30, 40};
      qb = '{5, 5, 5, 5};
      vpat = {};
      run_search(1'b0, 1, -1, cyc, to, sr);
      vectors++;
      if (to !== 1'b0) begin miscompares++; $display("[TB] FAIL single_timeout: done not seen within budget"); end
      vectors++;
      if (cyc !== 5) begin miscompares++; $display("[TB] FAIL single_latency: got %0d expected 5", cyc); end
      vectors++;
      if (if4.Best_SAD !== 16'd20) begin miscompares++; $display("[TB] FAIL single_best_sad: got %0d expected 20", if4.Best_SAD); end
      vectors++;
      if (if4.Best_Index !== 13'd1) begin miscompares++; $display("[TB] FAIL single_best_idx: got %0d expected 1", if4.Best_Index); end
      vectors++;
      if (sr !== 1'b1) begin miscompares++; $display("[TB] FAIL single_ready_seen: got %0b expected 1", sr); end
      @(posedge clk);
      #1;
      vectors++;
      if (if4.Done !== 1'b0) begin miscompares++; $display("[TB] FAIL single_done_pulse: got %0b expected 0", if4.Done); end
      vectors++;
      if (if4.Busy !== 1'b0) begin miscompares++; $display("[TB] FAIL single_back_idle: busy got %0b expected 0", if4.Busy); end
   endtask

   task automatic test_zero_pairs();
      int cyc; bit to; bit sr;
      qa = {};
      qb = {};
      vpat = {};
      run_search(1'b0, 0, -1, cyc, to, sr);
      vectors++;
      if (to !== 1'b0) begin miscompares++; $display("[TB] FAIL zero_timeout: done not seen within budget"); end
      vectors++;
      if (cyc !== 0) begin miscompares++; $display("[TB] FAIL zero_latency: got %0d expected 0", cyc); end
      vectors++;
      if (if4.Best_SAD !== 16'hFFFF) begin miscompares++; $display("[TB] FAIL zero_best_sad: got %0h expected ffff", if4.Best_SAD); end
      vectors++;
      if (if4.Best_Index !== 13'd0) begin miscompares++; $display("[TB] FAIL zero_best_idx: got %0d expected 0", if4.Best_Index); end
      vectors++;
      if (sr !== 1'b0) begin miscompares++; $display("[TB] FAIL zero_ready_seen: got %0b expected 0", sr); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_stall();
      int cyc; bit to; bit sr;
      qa = '{10, 20, 30, 40};
      qb = '{5, 5, 5, 5};
      vpat = '{1, 0, 0, 1, 1, 0, 1};
      run_search(1'b0, 1, -1, cyc, to, sr);
      vpat = {};
      vectors++;
      if (to !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_timeout: done not seen within budget"); end
      vectors++;
      if (cyc !== 8) begin miscompares++; $display("[TB] FAIL stall_latency: got %0d expected 8", cyc); end
      vectors++;
      if (if4.Best_SAD !== 16'd20) begin miscompares++; $display("[TB] FAIL stall_best_sad: got %0d expected 20", if4.Best_SAD); end
      vectors++;
      if (if4.Best_Index !== 13'd1) begin miscompares++; $display("[TB] FAIL stall_best_idx: got %0d expected 1", if4.Best_Index); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_back_to_back();
      int cyc; bit to; bit sr;
      qa = '{25, 25, 25, 25, 25, 25, 25, 25};
      qb = '{25, 25, 25, 25, 15, 15, 15, 15};
      vpat = {};
      run_search(1'b0, 2, -1, cyc, to, sr);
      vectors++;
      if (to !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_timeout: done not seen within budget"); end
      vectors++;
      if (cyc !== 10) begin miscompares++; $display("[TB] FAIL b2b_latency: got %0d expected 10", cyc); end
      vectors++;
      if (if4.Best_SAD !== 16'd60) begin miscompares++; $display("[TB] FAIL b2b_best_sad: got %0d expected 60", if4.Best_SAD); end
      vectors++;
      if (if4.Best_Index !== 13'd3) begin miscompares++; $display("[TB] FAIL b2b_best_idx: got %0d expected 3", if4.Best_Index); end
      repeat (4) @(posedge clk);
      #1;
      vectors++;
      if (if4.Best_SAD !== 16'd60) begin miscompares++; $display("[TB] FAIL b2b_hold_sad: got %0d expected 60", if4.Best_SAD); end
      vectors++;
      if (if4.Best_Index !== 13'd3) begin miscompares++; $display("[TB] FAIL b2b_hold_idx: got %0d expected 3", if4.Best_Index); end
   endtask

   task automatic test_tie_first_pair();
      int cyc; bit to; bit sr;
      qa = '{25, 25, 25, 25};
      qb = '{25, 25, 25, 25};
      vpat = {};
      run_search(1'b0, 1, -1, cyc, to, sr);
      vectors++;
      if (if4.Best_SAD !== 16'd100) begin miscompares++; $display("[TB] FAIL tie_best_sad: got %0d expected 100", if4.Best_SAD); end
      vectors++;
      if (if4.Best_Index !== 13'd0) begin miscompares++; $display("[TB] FAIL tie_best_idx: got %0d expected 0", if4.Best_Index); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid();
      int cyc; bit to; bit sr;
      num_pairs = 12'd1;
      start4    = 1'b1;
      @(posedge clk);
      #1;
      start4   = 1'b0;
      in_valid = 1'b1;
      sad_a    = 13'd100;
      sad_b    = 13'd100;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      vectors++;
      if (if4.Busy !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset_busy: got %0b expected 0", if4.Busy); end
      vectors++;
      if (if4.In_Ready !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset_ready: got %0b expected 0", if4.In_Ready); end
      vectors++;
      if (if4.Best_SAD !== 16'd0) begin miscompares++; $display("[TB] FAIL midreset_best_sad: got %0d expected 0", if4.Best_SAD); end
      rst_n    = 1'b1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      qa = '{1, 2, 3, 4};
      qb = '{4, 4, 4, 4};
      vpat = {};
      run_search(1'b0, 1, -1, cyc, to, sr);
      vectors++;
      if (cyc !== 5) begin miscompares++; $display("[TB] FAIL fresh_latency: got %0d expected 5", cyc); end
      vectors++;
      if (if4.Best_SAD !== 16'd10) begin miscompares++; $display("[TB] FAIL fresh_best_sad: got %0d expected 10", if4.Best_SAD); end
      vectors++;
      if (if4.Best_Index !== 13'd0) begin miscompares++; $display("[TB] FAIL fresh_best_idx: got %0d expected 0", if4.Best_Index); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_max_rows8();
      int cyc; bit to; bit sr;
      qa = {};
      qb = {};
      for (int i = 0; i < 8; i++) begin
         qa.push_back(8191);
         qb.push_back(8191);
      end
      vpat = {};
      run_search(1'b1, 1, 2, cyc, to, sr);
      vectors++;
      if (to !== 1'b0) begin miscompares++; $display("[TB] FAIL max_timeout: done not seen within budget"); end
      vectors++;
      if (cyc !== 9) begin miscompares++; $display("[TB] FAIL max_latency: got %0d expected 9", cyc); end
      vectors++;
      if (if8.Best_SAD !== 16'd65528) begin miscompares++; $display("[TB] FAIL max_best_sad: got %0d expected 65528", if8.Best_SAD); end
      vectors++;
      if (if8.Best_Index !== 13'd0) begin miscompares++; $display("[TB] FAIL max_best_idx: got %0d expected 0", if8.Best_Index); end
      @(posedge clk);
      #1;
      vectors++;
      if (if8.Busy !== 1'b0) begin miscompares++; $display("[TB] FAIL max_back_idle: busy got %0b expected 0", if8.Busy); end
   endtask

   // Scenario sequence followed by the single summary line
   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      start4      = 1'b0;
      start8      = 1'b0;
      num_pairs   = 12'd0;
      in_valid    = 1'b0;
      sad_a       = 13'd0;
      sad_b       = 13'd0;
      test_reset();
      test_single_pair();
      test_zero_pairs();
      test_stall();
      test_back_to_back();
      test_tie_first_pair();
      test_reset_mid();
      test_max_rows8();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
